// File: rtl/icache_refill_ctrl_pkg.sv
// Shared types and constants for the instruction-cache refill controller.
// Words are assembled little-endian: byte lane n occupies bits [8n+7:8n].
package icache_refill_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FETCH,
    FILL
  } state_e;

  localparam int WORD_BYTES = 4;
  localparam int LANE_W     = 8;

  function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [7:0]  b);
    logic [31:0] r;
    r = word;
    r[lane*LANE_W +: LANE_W] = b;
    return r;
  endfunction

endpackage

// File: rtl/icache_byte_assembler.sv
// Tracks in-flight memory bytes with a MEM_LAT-deep valid pipe and packs the
// returning bytes into a 32-bit word; done fires on the cycle the last byte lands.
module icache_byte_assembler
  import icache_refill_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic        issue,
  input  logic [7:0]  mem_byte,
  output logic [31:0] word,
  output logic        done
);

  logic [MEM_LAT-1:0] vpipe;
  logic [2:0]         recv_cnt;
  logic [31:0]        word_q;
  logic               byte_vld;

  assign byte_vld = vpipe[MEM_LAT-1];

  // The word output already includes the byte arriving this cycle, so the
  // FSM can latch a complete word on the same edge that receives the last byte.
  assign word = byte_vld ? insert_byte(word_q, recv_cnt[1:0], mem_byte) : word_q;
  assign done = byte_vld && (recv_cnt == 3'(WORD_BYTES - 1));

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      vpipe    <= '0;
      recv_cnt <= '0;
      word_q   <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        vpipe    <= '0;
        recv_cnt <= '0;
        word_q   <= '0;
      end else begin
        vpipe <= (vpipe << 1) | MEM_LAT'(issue);
        if (byte_vld) begin
          word_q   <= word;
          recv_cnt <= recv_cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache sequencer: answers hits in one cycle, and on a miss reads
// the word byte-by-byte over the shared memory port, fills the cache and returns it.
module icache_refill_ctrl
  import icache_refill_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_valid,
  output logic [31:0]       if_inst,
  output logic [ADDR_W-1:0] cache_addr,
  input  logic              cache_hit,
  input  logic [31:0]       cache_data,
  output logic              cache_upd,
  output logic [ADDR_W-1:0] cache_upd_addr,
  output logic [31:0]       cache_upd_data,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_byte
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  state_e            state;
  logic [ADDR_W-1:0] miss_addr;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        issue_cnt;
  logic              if_valid_q;
  logic              issuing;
  logic              asm_clear;
  logic              asm_done;
  logic [31:0]       asm_word;

  assign req_addr   = if_addr & ALIGN_MASK;
  assign cache_addr = (state == IDLE) ? req_addr : miss_addr;
  assign issuing    = (state == FETCH) && (issue_cnt < 3'(WORD_BYTES));
  assign asm_clear  = (state != FETCH) || if_flush;

  // A flush arriving during FILL still lets the cache update land but must
  // hide the instruction from fetch, so the registered pulse is gated here.
  assign if_valid = if_valid_q && !((state == FILL) && if_flush);

  icache_byte_assembler #(
    .MEM_LAT (MEM_LAT)
  ) u_asm (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .clear    (asm_clear),
    .issue    (issuing),
    .mem_byte (mem_byte),
    .word     (asm_word),
    .done     (asm_done)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state          <= IDLE;
      miss_addr      <= '0;
      issue_cnt      <= '0;
      if_valid_q     <= 1'b0;
      if_inst        <= '0;
      cache_upd      <= 1'b0;
      cache_upd_addr <= '0;
      cache_upd_data <= '0;
      mem_req        <= 1'b0;
      mem_addr       <= '0;
    end else if (rdy_in) begin
      if_valid_q <= 1'b0;
      cache_upd  <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req && !if_flush) begin
            if (cache_hit) begin
              if_valid_q <= 1'b1;
              if_inst    <= cache_data;
            end else begin
              miss_addr <= req_addr;
              mem_req   <= 1'b1;
              state     <= REQ;
            end
          end
        end
        REQ: begin
          if (if_flush) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end else if (mem_gnt) begin
            issue_cnt <= '0;
            mem_addr  <= miss_addr;
            state     <= FETCH;
          end
        end
        FETCH: begin
          if (if_flush) begin
            mem_req   <= 1'b0;
            issue_cnt <= '0;
            state     <= IDLE;
          end else begin
            // mem_addr is registered, so it is loaded one byte ahead of issue_cnt
            if (issuing) begin
              issue_cnt <= issue_cnt + 3'd1;
              if (issue_cnt < 3'(WORD_BYTES - 1))
                mem_addr <= miss_addr + ADDR_W'(issue_cnt + 3'd1);
            end
            if (asm_done) begin
              mem_req        <= 1'b0;
              cache_upd      <= 1'b1;
              cache_upd_addr <= miss_addr;
              cache_upd_data <= asm_word;
              if_valid_q     <= 1'b1;
              if_inst        <= asm_word;
              state          <= FILL;
            end
          end
        end
        FILL: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: one instance with MEM_LAT=1 for most
// scenarios and one with MEM_LAT=3 for the delayed-grant refill.
module tb_icache_refill_ctrl;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] if_addr;
  logic        if_flush;

  logic        req1, req3;
  logic        gnt_en1, gnt_en3;

  logic        if_valid1, if_valid3;
  logic [31:0] if_inst1, if_inst3;
  logic [31:0] cache_addr1, cache_addr3;
  logic        cache_hit1, cache_hit3;
  logic [31:0] cache_data1, cache_data3;
  logic        cache_upd1, cache_upd3;
  logic [31:0] cache_upd_addr1, cache_upd_addr3;
  logic [31:0] cache_upd_data1, cache_upd_data3;
  logic        mem_req1, mem_req3;
  logic        mem_gnt1, mem_gnt3;
  logic [31:0] mem_addr1, mem_addr3;
  logic [7:0]  mem_byte1, mem_byte3;

  int assert_cnt;
  int fail_cnt;

  icache_refill_ctrl #(.ADDR_W(32), .MEM_LAT(1)) u_dut1 (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .if_req         (req1),
    .if_addr        (if_addr),
    .if_flush       (if_flush),
    .if_valid       (if_valid1),
    .if_inst        (if_inst1),
    .cache_addr     (cache_addr1),
    .cache_hit      (cache_hit1),
    .cache_data     (cache_data1),
    .cache_upd      (cache_upd1),
    .cache_upd_addr (cache_upd_addr1),
    .cache_upd_data (cache_upd_data1),
    .mem_req        (mem_req1),
    .mem_gnt        (mem_gnt1),
    .mem_addr       (mem_addr1),
    .mem_byte       (mem_byte1)
  );

  icache_refill_ctrl #(.ADDR_W(32), .MEM_LAT(3)) u_dut3 (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .if_req         (req3),
    .if_addr        (if_addr),
    .if_flush       (if_flush),
    .if_valid       (if_valid3),
    .if_inst        (if_inst3),
    .cache_addr     (cache_addr3),
    .cache_hit      (cache_hit3),
    .cache_data     (cache_data3),
    .cache_upd      (cache_upd3),
    .cache_upd_addr (cache_upd_addr3),
    .cache_upd_data (cache_upd_data3),
    .mem_req        (mem_req3),
    .mem_gnt        (mem_gnt3),
    .mem_addr       (mem_addr3),
    .mem_byte       (mem_byte3)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Arbiter: grant follows the request once enabled, and is held while requested.
  assign mem_gnt1 = mem_req1 & gnt_en1;
  assign mem_gnt3 = mem_req3 & gnt_en3;

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h0000_2000: mem_rd = 8'h93;
      32'h0000_2001: mem_rd = 8'h00;
      32'h0000_2002: mem_rd = 8'h50;
      32'h0000_2003: mem_rd = 8'h00;
      32'h0000_3000: mem_rd = 8'h37;
      32'h0000_3001: mem_rd = 8'h01;
      32'h0000_3002: mem_rd = 8'h00;
      32'h0000_3003: mem_rd = 8'h80;
      32'h0000_4000: mem_rd = 8'hEF;
      32'h0000_4001: mem_rd = 8'hBE;
      32'h0000_4002: mem_rd = 8'hAD;
      32'h0000_4003: mem_rd = 8'hDE;
      32'hFFFF_FFFC: mem_rd = 8'h11;
      32'hFFFF_FFFD: mem_rd = 8'h22;
      32'hFFFF_FFFE: mem_rd = 8'h33;
      32'hFFFF_FFFF: mem_rd = 8'h44;
      default:       mem_rd = a[7:0] ^ 8'hA5;
    endcase
  endfunction

  // Byte-wide memories with 1 and 3 cycles of latency; they stall with rdy_in.
  logic [31:0] ap3_0, ap3_1;
  always @(posedge clk_in) begin
    if (rdy_in) begin
      mem_byte1 <= mem_rd(mem_addr1);
      ap3_0     <= mem_addr3;
      ap3_1     <= ap3_0;
      mem_byte3 <= mem_rd(ap3_1);
    end
  end

  // Cache model for the MEM_LAT=1 instance: 0x1000 is preloaded, three refill slots.
  logic [31:0] ctag [3];
  logic [31:0] cdat [3];
  logic [2:0]  cval = '0;
  logic [1:0]  cptr = '0;

  always_comb begin
    cache_hit1  = 1'b0;
    cache_data1 = '0;
    if (cache_addr1 == 32'h0000_1000) begin
      cache_hit1  = 1'b1;
      cache_data1 = 32'h0000_0013;
    end
    for (int i = 0; i < 3; i++) begin
      if (cval[i] && ctag[i] == cache_addr1) begin
        cache_hit1  = 1'b1;
        cache_data1 = cdat[i];
      end
    end
  end

  always @(posedge clk_in) begin
    if (cache_upd1 && rdy_in) begin
      ctag[cptr] <= cache_upd_addr1;
      cdat[cptr] <= cache_upd_data1;
      cval[cptr] <= 1'b1;
      cptr       <= (cptr == 2'd2) ? 2'd0 : cptr + 2'd1;
    end
  end

  // The MEM_LAT=3 instance only ever misses.
  assign cache_hit3  = 1'b0;
  assign cache_data3 = '0;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic applyStimulus(input logic r1, input logic r3,
                               input logic [31:0] addr, input logic fl);
    req1     = r1;
    req3     = r3;
    if_addr  = addr;
    if_flush = fl;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    assert_cnt++;
    assert (obs === exp)
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    assert_cnt = 0;
    fail_cnt   = 0;
    rst_in     = 1'b0;
    rdy_in     = 1'b1;
    gnt_en1    = 1'b1;
    gnt_en3    = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);

    tick();
    tick();
    checkOutput("rst_if_valid", 32'(if_valid1), 32'd0);
    checkOutput("rst_if_inst", if_inst1, 32'd0);
    checkOutput("rst_cache_upd", 32'(cache_upd1), 32'd0);
    checkOutput("rst_upd_addr", cache_upd_addr1, 32'd0);
    checkOutput("rst_upd_data", cache_upd_data1, 32'd0);
    checkOutput("rst_mem_req", 32'(mem_req1), 32'd0);
    checkOutput("rst_mem_addr", mem_addr1, 32'd0);
    checkOutput("rst_cache_addr", cache_addr1, 32'd0);
    rst_in = 1'b1;
    tick();

    $display("[TB] hit at 0x1002");
    applyStimulus(1'b1, 1'b0, 32'h0000_1002, 1'b0);
    #1;
    checkOutput("hit_cache_addr", cache_addr1, 32'h0000_1000);
    tick();
    checkOutput("hit_if_valid", 32'(if_valid1), 32'd1);
    checkOutput("hit_if_inst", if_inst1, 32'h0000_0013);
    checkOutput("hit_mem_req", 32'(mem_req1), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0000_1002, 1'b0);
    tick();
    checkOutput("hit_valid_pulse", 32'(if_valid1), 32'd0);
    checkOutput("hit_mem_req_after", 32'(mem_req1), 32'd0);

    $display("[TB] miss at 0x2000, MEM_LAT=1");
    applyStimulus(1'b1, 1'b0, 32'h0000_2000, 1'b0);
    tick();
    checkOutput("m1_req_state", 32'(mem_req1), 32'd1);
    checkOutput("m1_cache_addr", cache_addr1, 32'h0000_2000);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("m1_mem_addr", mem_addr1, 32'h0000_2000 + 32'(i));
      checkOutput("m1_no_valid", 32'(if_valid1), 32'd0);
    end
    tick();
    checkOutput("m1_req_held", 32'(mem_req1), 32'd1);
    tick();
    checkOutput("m1_if_valid", 32'(if_valid1), 32'd1);
    checkOutput("m1_if_inst", if_inst1, 32'h0050_0093);
    checkOutput("m1_cache_upd", 32'(cache_upd1), 32'd1);
    checkOutput("m1_upd_addr", cache_upd_addr1, 32'h0000_2000);
    checkOutput("m1_upd_data", cache_upd_data1, 32'h0050_0093);
    checkOutput("m1_mem_req_drop", 32'(mem_req1), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0000_2000, 1'b0);
    tick();
    checkOutput("m1_valid_pulse", 32'(if_valid1), 32'd0);
    checkOutput("m1_upd_pulse", 32'(cache_upd1), 32'd0);

    $display("[TB] delayed grant, MEM_LAT=3");
    applyStimulus(1'b0, 1'b1, 32'h0000_3000, 1'b0);
    tick();
    checkOutput("m3_req_wait", 32'(mem_req3), 32'd1);
    for (int i = 1; i < 5; i++) begin
      tick();
      checkOutput("m3_req_wait", 32'(mem_req3), 32'd1);
      checkOutput("m3_addr_idle", mem_addr3, 32'd0);
    end
    tick();
    gnt_en3 = 1'b1;
    checkOutput("m3_cache_addr", cache_addr3, 32'h0000_3000);
    for (int i = 1; i < 8; i++) begin
      tick();
      checkOutput("m3_no_valid", 32'(if_valid3), 32'd0);
    end
    tick();
    checkOutput("m3_if_valid", 32'(if_valid3), 32'd1);
    checkOutput("m3_if_inst", if_inst3, 32'h8000_0137);
    checkOutput("m3_cache_upd", 32'(cache_upd3), 32'd1);
    checkOutput("m3_upd_addr", cache_upd_addr3, 32'h0000_3000);
    checkOutput("m3_upd_data", cache_upd_data3, 32'h8000_0137);
    applyStimulus(1'b0, 1'b0, 32'h0000_3000, 1'b0);
    gnt_en3 = 1'b0;
    tick();
    checkOutput("m3_mem_req_low", 32'(mem_req3), 32'd0);

    $display("[TB] flush during refill");
    applyStimulus(1'b1, 1'b0, 32'h0000_5000, 1'b0);
    tick();
    tick();
    tick();
    tick();
    checkOutput("fl_mem_addr", mem_addr1, 32'h0000_5002);
    applyStimulus(1'b0, 1'b0, 32'h0000_5000, 1'b1);
    checkOutput("fl_req_before", 32'(mem_req1), 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0000_5000, 1'b0);
    checkOutput("fl_req_dropped", 32'(mem_req1), 32'd0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("fl_no_valid", 32'(if_valid1), 32'd0);
      checkOutput("fl_no_upd", 32'(cache_upd1), 32'd0);
      tick();
    end
    applyStimulus(1'b1, 1'b0, 32'h0000_1000, 1'b0);
    tick();
    checkOutput("fl_hit_valid", 32'(if_valid1), 32'd1);
    checkOutput("fl_hit_inst", if_inst1, 32'h0000_0013);
    applyStimulus(1'b0, 1'b0, 32'h0000_1000, 1'b0);
    tick();

    $display("[TB] rdy_in stall mid-refill");
    applyStimulus(1'b1, 1'b0, 32'h0000_4000, 1'b0);
    tick();
    tick();
    tick();
    checkOutput("st_mem_addr", mem_addr1, 32'h0000_4001);
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("st_frozen_addr", mem_addr1, 32'h0000_4001);
      checkOutput("st_frozen_req", 32'(mem_req1), 32'd1);
      checkOutput("st_frozen_valid", 32'(if_valid1), 32'd0);
    end
    rdy_in = 1'b1;
    tick();
    checkOutput("st_resume_addr", mem_addr1, 32'h0000_4002);
    tick();
    tick();
    tick();
    checkOutput("st_if_valid", 32'(if_valid1), 32'd1);
    checkOutput("st_if_inst", if_inst1, 32'hDEAD_BEEF);
    checkOutput("st_upd_data", cache_upd_data1, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 1'b0, 32'h0000_4000, 1'b0);
    tick();

    $display("[TB] async reset mid-refill, then miss at 0xFFFFFFFC");
    applyStimulus(1'b1, 1'b0, 32'h0000_6000, 1'b0);
    tick();
    tick();
    tick();
    #2;
    rst_in = 1'b0;
    #1;
    checkOutput("ar_mem_req", 32'(mem_req1), 32'd0);
    checkOutput("ar_mem_addr", mem_addr1, 32'd0);
    checkOutput("ar_if_valid", 32'(if_valid1), 32'd0);
    checkOutput("ar_cache_upd", 32'(cache_upd1), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0000_0000, 1'b0);
    tick();
    rst_in = 1'b1;
    tick();
    applyStimulus(1'b1, 1'b0, 32'hFFFF_FFFC, 1'b0);
    #1;
    checkOutput("ar_cache_addr", cache_addr1, 32'hFFFF_FFFC);
    tick();
    checkOutput("ar_req_state", 32'(mem_req1), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("ar_issue_addr", mem_addr1, 32'hFFFF_FFFC + 32'(i));
    end
    tick();
    tick();
    checkOutput("ar_if_valid_fill", 32'(if_valid1), 32'd1);
    checkOutput("ar_if_inst", if_inst1, 32'h4433_2211);
    checkOutput("ar_upd_addr", cache_upd_addr1, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b0, 32'h0000_0000, 1'b0);
    tick();
    checkOutput("ar_idle_req", 32'(mem_req1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
